// File: rtl/dm_store_rmw_pkg.sv
// rtl/dm_store_rmw_pkg.sv - opcodes, FSM encoding and lane masks for the store RMW block
package dm_pkg;

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        WR   = 2'd2
    } dm_state_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_B1   = 4'b0010;
    localparam logic [3:0] BE_B2   = 4'b0100;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    // sh needs halfword alignment, sw needs word alignment; sb is always legal
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
        return ((op == OP_SH) && off[0]) || ((op == OP_SW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_store_rmw_if.sv
// rtl/dm_store_rmw_if.sv - word-wide data memory port between the store unit and the memory
interface dm_store_rmw_if #(
    parameter int ADDR_W = 10
);
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_re, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata
    );

    modport slave (
        input  mem_re, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata
    );
endinterface

// File: rtl/dm_store_rmw_store_merge.sv
// rtl/dm_store_rmw_store_merge.sv - insert store data into a word and derive its byte-lane mask
module store_merge
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] data,
    input  logic [1:0]  offset,
    input  logic [5:0]  op,
    output logic [31:0] merged_word,
    output logic [3:0]  be
);

    // Overlay the stored byte/halfword onto old_word; untouched lanes pass through
    always_comb begin
        merged_word = old_word;
        be          = BE_NONE;
        case (op)
            OP_SB: begin
                case (offset)
                    2'd0: begin merged_word[7:0]   = data[7:0]; be = BE_B0; end
                    2'd1: begin merged_word[15:8]  = data[7:0]; be = BE_B1; end
                    2'd2: begin merged_word[23:16] = data[7:0]; be = BE_B2; end
                    default: begin merged_word[31:24] = data[7:0]; be = BE_B3; end
                endcase
            end
            OP_SH: begin
                if (offset[1]) begin
                    merged_word[31:16] = data[15:0];
                    be                 = BE_HI;
                end else begin
                    merged_word[15:0]  = data[15:0];
                    be                 = BE_LO;
                end
            end
            OP_SW: begin
                merged_word = data;
                be          = BE_ALL;
            end
            default: begin
                merged_word = old_word;
                be          = BE_NONE;
            end
        endcase
    end

endmodule

// File: rtl/dm_store_rmw.sv
// rtl/dm_store_rmw.sv - MEM-stage store unit; sb/sh via read-modify-write, or byte lanes when DM_BYTE_LANE_EN is defined
module dm_store_rmw
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   IR_M,
    input  logic [31:0]   ADDR,
    input  logic [31:0]   WD,
    input  logic          req_valid,
    output logic          stall,
    output logic          ades,
    dm_store_rmw_if.master mem
);

    dm_state_t         state_q, state_d;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_off;
    logic [5:0]        lat_op;
    logic [31:0]       lat_wd;
    logic [31:0]       wbuf;

    logic [5:0]        op;
    logic [1:0]        off;
    logic [ADDR_W-1:0] word_addr;
    logic              is_partial;
    logic              start_rmw;

    logic [31:0]       merge_old;
    logic [31:0]       merge_data;
    logic [1:0]        merge_off;
    logic [5:0]        merge_op;
    logic [31:0]       merged;
    logic [3:0]        merge_be;
    logic [3:0]        lane_be;

    logic              re_d, we_d, stall_d, ades_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       wdata_d;

    assign op         = IR_M[31:26];
    assign off        = ADDR[1:0];
    assign word_addr  = ADDR[ADDR_W+1:2];
    assign is_partial = (op == OP_SB) || (op == OP_SH);

`ifdef DM_BYTE_LANE_EN
    // Lane-capable memory: replicate the store data across lanes and let mem_be select
    assign merge_old  = (op == OP_SB) ? {4{WD[7:0]}} : {2{WD[15:0]}};
    assign merge_data = WD;
    assign merge_off  = off;
    assign merge_op   = op;
    assign lane_be    = merge_be;
`else
    // RMW: merge the latched store into the word just read back
    assign merge_old  = mem.mem_rdata;
    assign merge_data = lat_wd;
    assign merge_off  = lat_off;
    assign merge_op   = lat_op;
    assign lane_be    = BE_ALL;
`endif

    store_merge u_merge (
        .old_word    (merge_old),
        .data        (merge_data),
        .offset      (merge_off),
        .op          (merge_op),
        .merged_word (merged),
        .be          (merge_be)
    );

    // State register, request latches and the merged write buffer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            lat_addr <= '0;
            lat_off  <= '0;
            lat_op   <= '0;
            lat_wd   <= '0;
            wbuf     <= '0;
        end else begin
            state_q <= state_d;
            if (start_rmw) begin
                lat_addr <= word_addr;
                lat_off  <= off;
                lat_op   <= op;
                lat_wd   <= WD;
            end
            if (state_q == WAIT) begin
                wbuf <= merged;
            end
        end
    end

    // Next state and memory strobes; reset squashes every strobe so an aborted RMW never writes
    always_comb begin
        state_d   = state_q;
        re_d      = 1'b0;
        we_d      = 1'b0;
        stall_d   = 1'b0;
        ades_d    = 1'b0;
        addr_d    = word_addr;
        wdata_d   = '0;
        start_rmw = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(op, off)) begin
                        ades_d = 1'b1;
                    end else if (op == OP_SW) begin
                        we_d    = 1'b1;
                        wdata_d = WD;
                    end else if (is_partial) begin
`ifdef DM_BYTE_LANE_EN
                        we_d    = 1'b1;
                        wdata_d = merged;
`else
                        re_d      = 1'b1;
                        stall_d   = 1'b1;
                        start_rmw = 1'b1;
                        state_d   = WAIT;
`endif
                    end
                end
            end
            WAIT: begin
                addr_d  = lat_addr;
                stall_d = 1'b1;
                state_d = WR;
            end
            WR: begin
                addr_d  = lat_addr;
                we_d    = 1'b1;
                wdata_d = wbuf;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            re_d      = 1'b0;
            we_d      = 1'b0;
            stall_d   = 1'b0;
            ades_d    = 1'b0;
            start_rmw = 1'b0;
            state_d   = IDLE;
        end
    end

    assign stall         = stall_d;
    assign ades          = ades_d;
    assign mem.mem_re    = re_d;
    assign mem.mem_we    = we_d;
    assign mem.mem_addr  = addr_d;
    assign mem.mem_wdata = wdata_d;
    assign mem.mem_be    = we_d ? lane_be : BE_NONE;

endmodule

// File: tb/tb_dm_store_rmw.sv
// tb/tb_dm_store_rmw.sv - directed self-checking bench for dm_store_rmw
module tb_dm_store_rmw;
    import dm_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M, ADDR, WD;
    logic        req_valid;
    logic        stall, ades;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] mem_arr [0:1023];
    logic        pl_en = 1'b0;
    logic [31:0] pl_val = '0;
    logic        watch = 1'b0;
    logic        we_seen = 1'b0;

    always #5 clk = ~clk;

    dm_store_rmw_if #(.ADDR_W(10)) m ();

    dm_store_rmw #(.ADDR_W(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .IR_M      (IR_M),
        .ADDR      (ADDR),
        .WD        (WD),
        .req_valid (req_valid),
        .stall     (stall),
        .ades      (ades),
        .mem       (m)
    );

    // Synchronous memory model: read data one cycle after mem_re; word 4 can be preloaded
    always @(posedge clk) begin
        if (pl_en) mem_arr[4] <= pl_val;
        else if (m.mem_we) mem_arr[m.mem_addr] <= m.mem_wdata;
        if (m.mem_re) m.mem_rdata <= mem_arr[m.mem_addr];
        if (watch && m.mem_we) we_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic apply(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd, input logic v);
        @(negedge clk);
        IR_M      = {op, 26'h0};
        ADDR      = addr;
        WD        = wd;
        req_valid = v;
        #1;
    endtask

    task automatic preload(input logic [31:0] v);
        @(negedge clk);
        req_valid = 1'b0;
        pl_en     = 1'b1;
        pl_val    = v;
        @(negedge clk);
        pl_en     = 1'b0;
    endtask

    task automatic no_access(input string tag, input logic exp_ades);
        chk({tag, "_ades"},  32'(ades), 32'(exp_ades));
        chk({tag, "_we"},    32'(m.mem_we), 0);
        chk({tag, "_re"},    32'(m.mem_re), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
    endtask

    task automatic single(input string tag, input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] ea, input logic [31:0] ed, input logic [31:0] eb);
        apply(op, addr, wd, 1'b1);
        chk({tag, "_we"},    32'(m.mem_we), 1);
        chk({tag, "_re"},    32'(m.mem_re), 0);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_addr"},  32'(m.mem_addr), ea);
        chk({tag, "_data"},  m.mem_wdata, ed);
        chk({tag, "_be"},    32'(m.mem_be), eb);
    endtask

    task automatic rmw(input string tag, input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] ea, input logic [31:0] ed);
        apply(op, addr, wd, 1'b1);
        chk({tag, "_c0_re"},    32'(m.mem_re), 1);
        chk({tag, "_c0_stall"}, 32'(stall), 1);
        chk({tag, "_c0_we"},    32'(m.mem_we), 0);
        chk({tag, "_c0_addr"},  32'(m.mem_addr), ea);
        @(negedge clk); #1;
        chk({tag, "_c1_stall"}, 32'(stall), 1);
        chk({tag, "_c1_re"},    32'(m.mem_re), 0);
        chk({tag, "_c1_we"},    32'(m.mem_we), 0);
        @(negedge clk); #1;
        chk({tag, "_c2_we"},    32'(m.mem_we), 1);
        chk({tag, "_c2_stall"}, 32'(stall), 0);
        chk({tag, "_c2_addr"},  32'(m.mem_addr), ea);
        chk({tag, "_c2_data"},  m.mem_wdata, ed);
        chk({tag, "_c2_be"},    32'(m.mem_be), 32'hF);
    endtask

    initial begin
        reset = 1'b1;
        IR_M = {OP_SW, 26'h0};
        ADDR = 32'h10;
        WD = 32'h1;
        req_valid = 1'b1;
        for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        no_access("reset", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;

`ifdef DM_BYTE_LANE_EN
        single("lane_sb3", OP_SB, 32'h13, 32'h7F, 4, 32'h7F7F7F7F, 32'h8);
        single("lane_sb0", OP_SB, 32'h10, 32'h12, 4, 32'h12121212, 32'h1);
        single("lane_sh2", OP_SH, 32'h12, 32'hBEEF, 4, 32'hBEEFBEEF, 32'hC);
        single("lane_sh0", OP_SH, 32'h10, 32'h5566, 4, 32'h55665566, 32'h3);
        single("lane_sw",  OP_SW, 32'h10, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'hF);
        apply(OP_SH, 32'h13, 32'h1, 1'b1);
        no_access("lane_mis_sh", 1'b1);
`else
        single("sw", OP_SW, 32'h10, 32'hDEADBEEF, 4, 32'hDEADBEEF, 32'hF);
        @(negedge clk);
        chk("sw_mem", mem_arr[4], 32'hDEADBEEF);

        preload(32'h11223344);
        rmw("sb12", OP_SB, 32'h12, 32'h000000AA, 4, 32'h11AA3344);

        preload(32'h11223344);
        rmw("sh12", OP_SH, 32'h12, 32'h0000BEEF, 4, 32'hBEEF3344);
        rmw("sh10", OP_SH, 32'h10, 32'h00005566, 4, 32'hBEEF5566);
        rmw("sb13", OP_SB, 32'h13, 32'hFFFFFF77, 4, 32'h77EF5566);
        rmw("sb10", OP_SB, 32'h10, 32'h00000001, 4, 32'h77EF5501);
        rmw("sb_w9", OP_SB, 32'h25, 32'h000000C3, 9, 32'h0000C300);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_mem", mem_arr[4], 32'h77EF5501);

        apply(OP_SH, 32'h13, 32'h1234, 1'b1);
        no_access("mis_sh13", 1'b1);
        apply(OP_SW, 32'h16, 32'h1234, 1'b1);
        no_access("mis_sw16", 1'b1);
        apply(OP_SW, 32'h11, 32'h1234, 1'b1);
        no_access("mis_sw11", 1'b1);
        apply(6'b100011, 32'h10, 32'h1234, 1'b1);
        no_access("nonstore", 1'b0);
        apply(OP_SW, 32'h10, 32'h1234, 1'b0);
        no_access("novalid", 1'b0);

        // Abort in WAIT
        watch = 1'b1;
        apply(OP_SB, 32'h12, 32'h55, 1'b1);
        chk("abw_re", 32'(m.mem_re), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        no_access("abw_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        no_access("abw_after", 1'b0);
        @(negedge clk); #1;
        no_access("abw_after2", 1'b0);

        // Abort in WR
        apply(OP_SH, 32'h10, 32'h9999, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        no_access("abr_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        watch = 1'b0;
        chk("abort_no_we", 32'(we_seen), 0);
        chk("abort_mem", mem_arr[4], 32'h77EF5501);

        single("sw_post", OP_SW, 32'h14, 32'hCAFEF00D, 5, 32'hCAFEF00D, 32'hF);
`endif
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_store_rmw.md
Name: dm_store_rmw

Overview:
- Store-side counterpart of the load data extender: converts MEM-stage sb/sh/sw into word-wide data-memory writes.
- The data memory has no byte lanes, so sb/sh run a read-modify-write sequence; sw writes directly.
- Sits between MEM-stage pipeline registers (IR_M, ALU address, store data) and the synchronous data memory.
- Drives a stall back to the hazard unit while a partial-word store is in flight.

Parameters:
- ADDR_W, 10, word-address width of data memory (1024 words)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- IR_M  input  32  MEM-stage instruction; opcode IR_M[31:26]
- ADDR  input  32  byte address from ALU
- WD  input  32  store data (rt value, forwarded)
- req_valid  input  1  MEM stage holds a valid (non-bubble) instruction
- stall  output  1  hold F/D/E/M stages
- ades  output  1  address-error-on-store pulse
- mem_re  output  1  memory read strobe
- mem_we  output  1  memory write strobe
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  32  write data
- mem_be  output  4  byte enables
- mem_rdata  input  32  read data, valid one cycle after mem_re

Behaviour:
- Opcodes: sb=101000, sh=101001, sw=101011. Any other opcode, or req_valid=0, is a no-op.
- Offset is ADDR[1:0]. mem_addr = ADDR[ADDR_W+1:2] in IDLE; in WAIT/WR it is the latched address.
- Misalignment: sh with ADDR[0]=1, or sw with ADDR[1:0]!=0.
  - ades=1 for that cycle in IDLE; no read, no write, no stall.
- FSM states: IDLE, WAIT, WR.
- IDLE:
  - sw aligned: mem_we=1, mem_wdata=WD, stall=0; stay IDLE (single cycle).
  - sb, or sh aligned: mem_re=1, stall=1; latch word address, offset, opcode and WD; go to WAIT.
- WAIT:
  - stall=1.
  - Merge mem_rdata with the latched data into wbuf.
    - sb offset k: byte k takes WD[7:0]; other bytes come from mem_rdata.
    - sh offset 0: [15:0] takes WD[15:0]. sh offset 2: [31:16] takes WD[15:0].
  - Go to WR.
- WR: mem_we=1, mem_wdata=wbuf, stall=0; go to IDLE. The pipeline advances on this edge.
- Cycle counts: sb/sh = 3 cycles total, stall high for 2. sw = 1 cycle.
- mem_be: 4'b1111 whenever mem_we=1 (no-macro build).
- Inputs are ignored in WAIT/WR; the pipeline is frozen by stall.
- Reset values: state=IDLE; stall, mem_re, mem_we, ades = 0; wbuf and latches = 0.
- Reset in WAIT or WR aborts the store: no write is issued and the FSM returns to IDLE next cycle.
- Back-to-back stores to the same word are correct: the second read follows the first write.

Optional Feature:
- DM_BYTE_LANE_EN defined: memory honours mem_be.
  - sb/sh complete in one IDLE cycle with no stall.
  - WD is replicated to all lanes: sb → {4{WD[7:0]}}, sh → {2{WD[15:0]}}.
  - mem_be: sb = one-hot by offset (offset 0 → 0001). sh offset 0 → 0011, offset 2 → 1100. sw → 1111.
  - WAIT/WR are unused; mem_re is never asserted.
- DM_BYTE_LANE_EN undefined: RMW behaviour as above, mem_be=1111.

Decomposition:
- Package dm_pkg holds:
  - opcode constants OP_SB, OP_SH, OP_SW;
  - FSM state encoding (IDLE/WAIT/WR);
  - lane-mask constants.
- One combinational sub-module, store_merge: (old_word, data, offset, op) → merged_word plus be.
  - Shared by the RMW path and the byte-lane path.
  - Unit-testable on its own.

Test Plan:
- sw ADDR=0x10, WD=0xDEADBEEF → same cycle mem_we=1, mem_addr=4, mem_wdata=0xDEADBEEF, stall=0.
- Memory word 4 = 0x11223344; sb ADDR=0x12, WD=0x000000AA → mem_re in cycle0, stall high cycles 0–1, cycle2 mem_we with data 0x11AA3344.
- Memory word 4 = 0x11223344; sh ADDR=0x12, WD=0x0000BEEF → cycle2 write 0xBEEF3344; then sh ADDR=0x10 WD=0x5566 → 0xBEEF5566.
- sh ADDR=0x13, then sw ADDR=0x16 → ades=1 each cycle, mem_we=0, mem_re=0, stall=0.
- sb issued, reset asserted in WAIT → no mem_we ever, next cycle state IDLE, stall=0.
- With DM_BYTE_LANE_EN: sb ADDR=0x13, WD=0x7F → single cycle, mem_be=1000, mem_wdata=0x7F7F7F7F, stall=0.
